// File: rtl/div_shift_seq_reg.sv
// div_shift_seq_reg: parametrised shift register for the sequential divider
// datapath. Commands (load, clear, shift, rotate) are strobed in with start.
// Multi-cycle shifts run one position per clock with busy high. A single-cycle
// done pulse marks completion.
// Optional feature macro: DIV_SHIFT_ROTATE_EN enables ROL/ROR. When it is not
// defined, ROL/ROR act as HOLD and no rotate logic is built.
module div_shift_seq_reg #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             sh_in,
    output logic [WIDTH-1:0] Q,
    output logic             sh_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SL   = 3'b010;
    localparam logic [2:0] OP_SR   = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t           state;
    logic [2:0]       op_l;
    logic [AMT_W-1:0] count;
    logic             is_shift;

    // Decode which opcodes run through the multi-cycle shift engine.
    always_comb begin
        is_shift = (op == OP_SL) || (op == OP_SR) || (op == OP_ASR);
`ifdef DIV_SHIFT_ROTATE_EN
        if ((op == OP_ROL) || (op == OP_ROR))
            is_shift = 1'b1;
`endif
    end

    // Control FSM and datapath: accept commands in IDLE, shift in SHIFT,
    // pulse done in FIN. Commands that arrive outside IDLE are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            Q      <= '0;
            sh_out <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            op_l   <= OP_HOLD;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (is_shift && (amt != '0)) begin
                            // Anything past WIDTH is fully shifted out, so clamp.
                            count <= (amt > AMT_MAX) ? AMT_MAX : amt;
                            op_l  <= op;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            if (op == OP_LOAD)
                                Q <= D;
                            else if (op == OP_CLR)
                                Q <= '0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                SHIFT: begin
                    case (op_l)
                        OP_SL: begin
                            Q      <= {Q[WIDTH-2:0], sh_in};
                            sh_out <= Q[WIDTH-1];
                        end
                        OP_SR: begin
                            Q      <= {1'b0, Q[WIDTH-1:1]};
                            sh_out <= Q[0];
                        end
                        OP_ASR: begin
                            Q      <= {Q[WIDTH-1], Q[WIDTH-1:1]};
                            sh_out <= Q[0];
                        end
`ifdef DIV_SHIFT_ROTATE_EN
                        OP_ROL: begin
                            Q      <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                            sh_out <= Q[WIDTH-1];
                        end
                        OP_ROR: begin
                            Q      <= {Q[0], Q[WIDTH-1:1]};
                            sh_out <= Q[0];
                        end
`endif
                        default: ;
                    endcase
                    count <= count - 1'b1;
                    // The shift on count==1 is the last one.
                    if (count == AMT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_shift_seq_reg.sv
// Scoreboard bench for div_shift_seq_reg (WIDTH=8). Each command pushes its
// expected result, latency and busy length. These are popped and compared
// when done is seen.
module tb_div_shift_seq_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       sh_in;
    logic [7:0] q;
    logic       sh_out, busy, done;

    div_shift_seq_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .D(d),
        .sh_in(sh_in), .Q(q), .sh_out(sh_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       sh;
        int         lat;
        int         nbusy;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mq;
    logic       msh;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour, applied to the bench's own copy of the register.
    task automatic model(input logic [2:0] o, input logic [3:0] a, input logic [7:0] dd,
                         input logic si, output exp_t e);
        int n;
        bit sh;
        n  = (a > 4'd8) ? 8 : int'(a);
        sh = (o == 3'b010) || (o == 3'b011) || (o == 3'b100);
`ifdef DIV_SHIFT_ROTATE_EN
        if (o == 3'b101 || o == 3'b110) sh = 1'b1;
`endif
        if (o == 3'b001) mq = dd;
        else if (o == 3'b111) mq = 8'h00;
        else if (sh) begin
            for (int i = 0; i < n; i++) begin
                case (o)
                    3'b010: begin msh = mq[7]; mq = {mq[6:0], si}; end
                    3'b011: begin msh = mq[0]; mq = {1'b0, mq[7:1]}; end
                    3'b100: begin msh = mq[0]; mq = {mq[7], mq[7:1]}; end
                    3'b101: begin msh = mq[7]; mq = {mq[6:0], mq[7]}; end
                    3'b110: begin msh = mq[0]; mq = {mq[0], mq[7:1]}; end
                    default: ;
                endcase
            end
        end
        e.q     = mq;
        e.sh    = msh;
        e.lat   = (sh && n > 0) ? n + 1 : 1;
        e.nbusy = (sh && n > 0) ? n : 0;
    endtask

    // Issue one command and check it when done appears. With ign set, spurious
    // LOADs are strobed while busy and again during the done cycle.
    task automatic cmd(input string tag, input logic [2:0] o, input logic [3:0] a,
                       input logic [7:0] dd, input logic si, input bit ign);
        exp_t e;
        int   cyc, nb;
        model(o, a, dd, si, e);
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; amt = a; d = dd; sh_in = si;
        @(negedge clk);
        start = 1'b0; op = 3'b000; amt = 4'd0; d = 8'h00;
        cyc = 1;
        nb  = 0;
        while (!done && cyc < 64) begin
            if (busy) nb++;
            if (ign && cyc == 2) begin start = 1'b1; op = 3'b001; d = 8'h3C; amt = 4'd1; end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        e = sbq.pop_front();
        check({tag, " latency"}, cyc, e.lat);
        check({tag, " busy cycles"}, nb, e.nbusy);
        check({tag, " Q"}, q, e.q);
        check({tag, " sh_out"}, sh_out, e.sh);
        check({tag, " busy at done"}, busy, 1'b0);
        if (ign) begin start = 1'b1; op = 3'b001; d = 8'h3C; end
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        check({tag, " done one cycle"}, done, 1'b0);
        if (ign) check({tag, " Q after FIN start"}, q, e.q);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; amt = 4'd0; d = 8'h00; sh_in = 1'b0;
        mq = 8'h00; msh = 1'b0;
        repeat (2) @(negedge clk);
        check("reset Q", q, 8'h00);
        check("reset sh_out", sh_out, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        rst = 1'b0;

        cmd("load A5", 3'b001, 4'd0, 8'hA5, 1'b0, 1'b0);
        cmd("hold", 3'b000, 4'd3, 8'h11, 1'b0, 1'b0);
        cmd("load 81", 3'b001, 4'd0, 8'h81, 1'b0, 1'b0);
        cmd("sl3", 3'b010, 4'd3, 8'h00, 1'b1, 1'b0);
        cmd("sr amt0", 3'b011, 4'd0, 8'h00, 1'b0, 1'b0);
        cmd("load 80", 3'b001, 4'd0, 8'h80, 1'b0, 1'b0);
        cmd("asr9", 3'b100, 4'd9, 8'h00, 1'b0, 1'b0);
        cmd("load 80b", 3'b001, 4'd0, 8'h80, 1'b0, 1'b0);
        cmd("sr9", 3'b011, 4'd9, 8'h00, 1'b0, 1'b0);
        cmd("load 81b", 3'b001, 4'd0, 8'h81, 1'b0, 1'b0);
        cmd("ror1", 3'b110, 4'd1, 8'h00, 1'b0, 1'b0);
        cmd("rol3", 3'b101, 4'd3, 8'h00, 1'b0, 1'b0);
        cmd("load FF", 3'b001, 4'd0, 8'hFF, 1'b0, 1'b0);
        cmd("sr5 ignore", 3'b011, 4'd5, 8'h00, 1'b0, 1'b1);
        cmd("sl8 fill1", 3'b010, 4'd8, 8'h00, 1'b1, 1'b0);
        cmd("clr", 3'b111, 4'd0, 8'hEE, 1'b0, 1'b0);

        // Abort a shift with reset while two shifts remain.
        cmd("load C3", 3'b001, 4'd0, 8'hC3, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'b010; amt = 4'd4; sh_in = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'b000; amt = 4'd0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort Q", q, 8'h00);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort sh_out", sh_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mq = 8'h00; msh = 1'b0;
        cmd("post-reset load", 3'b001, 4'd0, 8'h5A, 1'b0, 1'b0);
        cmd("post-reset sr1", 3'b011, 4'd1, 8'h00, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++)
            cmd("rand", 3'($urandom_range(7)), 4'($urandom_range(15)),
                8'($urandom), 1'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
